// File: rtl/axi4_lite_max7219.sv
// rtl/axi4_lite_max7219.sv - AXI4-Lite register bank serialising 16-bit frames onto a MAX7219.
// Optional feature: define AXI4_LITE_MAX7219_IRQ_EN for CTRL.IRQ_EN and the irq output.
module axi4_lite_max7219 #(
    parameter int G_ADDR_WIDTH  = 4,
    parameter int G_CLK_DIV_RST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [G_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [G_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    max7219_din,
    output logic                    max7219_clk,
    output logic                    max7219_load
`ifdef AXI4_LITE_MAX7219_IRQ_EN
    ,
    output logic                    irq
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT_LO, S_SHIFT_HI, S_LATCH} state_t;

    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_DATA    = 2'd2;
    localparam logic [1:0] A_CLK_DIV = 2'd3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state;
    logic        enable;
    logic        irq_en;
    logic        done;
    logic [15:0] data_reg;
    logic [15:0] shreg;
    logic [7:0]  clk_div;
    logic [7:0]  div;
    logic [7:0]  cnt;
    logic [3:0]  bit_idx;

    logic        busy;
    logic        wr_hs;
    logic        rd_hs;
    logic [1:0]  wr_sel;
    logic [1:0]  rd_sel;
    logic        frame_start;
    logic        data_reject;
    logic        done_set;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign busy        = (state != S_IDLE);
    assign wr_hs       = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
    assign rd_hs       = s_axi_arready & s_axi_arvalid;
    assign wr_sel      = s_axi_awaddr[3:2];
    assign rd_sel      = s_axi_araddr[3:2];
    assign frame_start = wr_hs && (wr_sel == A_DATA) && enable && !busy;
    assign data_reject = wr_hs && (wr_sel == A_DATA) && !frame_start;
    assign done_set    = (state == S_LATCH) && (cnt == div);
    assign s_axi_rresp = RESP_OKAY;
    assign unused_ok   = ^{s_axi_wstrb, s_axi_wdata[31:16], s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        rd_mux = 32'h0;
        case (rd_sel)
            A_CTRL:    rd_mux = {30'h0, irq_en, enable};
            A_STATUS:  rd_mux = {30'h0, done, busy};
            A_DATA:    rd_mux = {16'h0, data_reg};
            A_CLK_DIV: rd_mux = {24'h0, clk_div};
            default:   rd_mux = 32'h0;
        endcase
    end

    // AXI handshakes and register bank; ready pulses are self-clearing so each request is taken once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'h0;
            enable        <= 1'b0;
            done          <= 1'b0;
            data_reg      <= 16'h0;
            clk_div       <= 8'(G_CLK_DIV_RST);
        end else begin
            s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
            s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
            if (wr_hs) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= data_reject ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
            if (rd_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end

            if (wr_hs && (wr_sel == A_CTRL))
                enable <= s_axi_wdata[0];
            if (frame_start)
                data_reg <= s_axi_wdata[15:0];
            if (wr_hs && (wr_sel == A_CLK_DIV))
                clk_div <= s_axi_wdata[7:0];
            // A frame completing in the same cycle as a W1C keeps DONE set.
            if (wr_hs && (wr_sel == A_STATUS) && s_axi_wdata[1])
                done <= 1'b0;
            if (done_set)
                done <= 1'b1;
        end
    end

`ifdef AXI4_LITE_MAX7219_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_en <= 1'b0;
        else if (wr_hs && (wr_sel == A_CTRL))
            irq_en <= s_axi_wdata[1];
    end

    assign irq = done & irq_en;
`else
    assign irq_en = 1'b0;
`endif

    // Serializer: every phase lasts div+1 cycles; div is frozen at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= 8'h0;
            div          <= 8'h0;
            bit_idx      <= 4'h0;
            shreg        <= 16'h0;
            max7219_load <= 1'b1;
            max7219_clk  <= 1'b0;
            max7219_din  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state        <= S_SHIFT_LO;
                        cnt          <= 8'h0;
                        div          <= clk_div;
                        shreg        <= s_axi_wdata[15:0];
                        bit_idx      <= 4'h0;
                        max7219_load <= 1'b0;
                        max7219_din  <= s_axi_wdata[15];
                    end
                end
                S_SHIFT_LO: begin
                    if (cnt == div) begin
                        cnt         <= 8'h0;
                        state       <= S_SHIFT_HI;
                        max7219_clk <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SHIFT_HI: begin
                    if (cnt == div) begin
                        cnt         <= 8'h0;
                        max7219_clk <= 1'b0;
                        if (bit_idx == 4'd15) begin
                            state       <= S_LATCH;
                            max7219_din <= 1'b0;
                        end else begin
                            state       <= S_SHIFT_LO;
                            bit_idx     <= bit_idx + 4'd1;
                            shreg       <= {shreg[14:0], 1'b0};
                            max7219_din <= shreg[14];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_LATCH: begin
                    if (cnt == div) begin
                        cnt          <= 8'h0;
                        state        <= S_IDLE;
                        max7219_load <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_lite_max7219.md
# axi4_lite_max7219

AXI4-Lite slave that exposes a small register bank and serialises 16-bit command frames onto the MAX7219 3-wire interface (DIN/CLK/LOAD). It is the DUT instantiated in the AXI4-Lite MAX7219 testbench top. The bench drives its AXI4-Lite port and monitors its pins through the generic set/wait/check modules. One frame is in flight at a time; software polls BUSY/DONE or uses the optional interrupt.

## Interface
- G_ADDR_WIDTH, 4: AXI address width. Decode uses bits [3:2]; bits [1:0] are ignored.
- G_CLK_DIV_RST, 4: reset value of CLK_DIV[7:0].
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  G_ADDR_WIDTH  write address; s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata  in  32  write data; s_axi_wstrb in 4 (ignored, full-word writes); s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bresp  out  2  write response; s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_araddr  in  G_ADDR_WIDTH  read address; s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata  out  32  read data; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
- max7219_din  out  1  serial data, MSB first.
- max7219_clk  out  1  serial clock; the MAX7219 samples DIN on the rising edge.
- max7219_load  out  1  latch; low during a frame, and its rising edge latches the frame.
- irq  out  1  frame-done interrupt (present only with the macro).

## Operation
- Registers:
  - 0x0 CTRL (RW): bit0 ENABLE (reset 0), bit1 IRQ_EN (macro only, reset 0).
  - 0x4 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear).
  - 0x8 DATA (RW): bits[15:0] hold the frame. Reads return the last frame accepted.
  - 0xC CLK_DIV (RW): bits[7:0] set the divider.
  - Unused register bits read 0. Unmapped addresses do not exist for a 4-bit address.
- A write to DATA with ENABLE=1 and BUSY=0 starts a frame and returns OKAY.
- A write to DATA with ENABLE=0 or BUSY=1 returns SLVERR (2'b10). The frame is discarded and DATA is unchanged.
- Serializer FSM: IDLE -> SHIFT_LO -> SHIFT_HI -> (repeats 16 times) -> LATCH -> IDLE.
  - A frame start latches DIV=CLK_DIV and the 16-bit shift register. Each phase lasts DIV+1 clk cycles.
  - IDLE: load=1, clk=0, din=0.
  - SHIFT_LO: load=0, clk=0, din=current bit.
  - SHIFT_HI: clk=1, din held.
  - LATCH: clk=0, load=0 for DIV+1 cycles. On exit, load returns to 1, BUSY clears and DONE sets.
- DONE set and a W1C write in the same cycle: the set wins.
- A CLK_DIV write during BUSY is accepted, but affects only the next frame.

## Timing
- Reset values: all ready/valid outputs 0, bresp=rresp=0, rdata=0, load=1, clk=0, din=0, irq=0. The FSM is in IDLE.
- Write channel:
  - awready and wready pulse together for one cycle once awvalid and wvalid are both high and bvalid=0. AW and W may arrive in either order.
  - bvalid rises the next cycle and holds until bready.
- Read channel:
  - arready pulses for one cycle when arvalid is high and rvalid=0.
  - rvalid rises the next cycle with the data, and holds until rready.
- Frame timing:
  - BUSY reads 1 from the cycle after the accepting handshake.
  - load falls in that same cycle.
  - A frame is 33*(DIV+1) clk cycles from load falling to load rising.
- Reset asserted mid-frame: outputs return immediately to their reset values. The partial frame is never latched because load rises without a clk edge, and the MAX7219 ignores a partial frame.

## Configuration
- AXI4_LITE_MAX7219_IRQ_EN defined:
  - The irq port and the CTRL.IRQ_EN bit exist.
  - irq is a level equal to DONE & IRQ_EN and clears when DONE is cleared.
- Macro undefined: there is no irq port, and CTRL bit1 reads 0 and ignores writes.

## Test plan
- Reset only -> load=1, clk=0, din=0. Reads: CLK_DIV=0x4, CTRL=0x0, STATUS=0x0.
- Write CTRL=0x1, then DATA=0x0A5F with DIV=4 -> 16 rising clk edges with din bits 0000101001011111, each bit 10 cycles apart. load is low for 165 cycles. Then STATUS=0x2.
- Write DATA during BUSY -> bresp=SLVERR, and reading DATA still returns the first frame. Write DATA with ENABLE=0 -> SLVERR and no load activity.
- Write STATUS=0x2 in the same cycle DONE sets -> DONE stays 1. A later write of 0x2 -> STATUS=0x0.
- Write CLK_DIV=0 mid-frame -> the current frame keeps 10-cycle bits. The next frame uses 2-cycle bits and has load low for 33 cycles.
- With the macro, IRQ_EN=1 -> irq rises when load rises and falls after the DONE W1C. Pulse rst_n mid-frame -> load=1 and clk=0 immediately, and BUSY=0 afterwards.
